// File: rtl/bit_seq_pkg.sv
// Shared constants for the serial pattern transmitter: one-hot FSM encodings
// and the state vector width.
package bit_seq_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE  = 4'b0001;
    localparam logic [STATE_W-1:0] ST_SHIFT = 4'b0010;
    localparam logic [STATE_W-1:0] ST_GAP   = 4'b0100;
    localparam logic [STATE_W-1:0] ST_DONE  = 4'b1000;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register, MSB first. Load wins over shift; shifting
// fills zeros from the bottom, so a fully shifted word reads back as zero.
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] data_q;

    // Shift register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            data_q <= din_i;
        end else if (shift_i) begin
            data_q <= {data_q[WIDTH-2:0], 1'b0};
        end else begin
            data_q <= data_q;
        end
    end

    assign msb_o = data_q[WIDTH-1];

endmodule

// File: rtl/bit_seq_tx.sv
// Serial pattern transmitter: captures a word on load and shifts it out MSB
// first, optionally repeating it with an idle gap between frames.
module bit_seq_tx
    import bit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2,
    parameter int unsigned REP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [REP_W-1:0]   rep_in,
    output logic               ready,
    output logic               dout,
    output logic               dout_valid,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit GAP_EN = (GAP > 0);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_CW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               ready_q, valid_q, done_q;
    logic               sh_load_s, sh_shift_s;
    logic [WIDTH-1:0]   sh_din_s;

    // Next-state, counter and shift-control decode
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        hold_d     = hold_q;
        sh_load_s  = 1'b0;
        sh_shift_s = 1'b0;
        sh_din_s   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    hold_d    = data_in;
                    rep_cnt_d = rep_in;
                    bit_cnt_d = {CNT_W{1'b0}};
                    sh_load_s = 1'b1;
                    sh_din_s  = data_in;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = {CNT_W{1'b0}};
                    if (rep_cnt_q != {REP_W{1'b0}}) begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        if (GAP_EN) begin
                            // Shifting out the last bit leaves the register zero for the gap
                            sh_shift_s = 1'b1;
                            gap_cnt_d  = {GAP_CW{1'b0}};
                            state_d    = ST_GAP;
                        end else begin
                            sh_load_s = 1'b1;
                            state_d   = ST_SHIFT;
                        end
                    end else begin
                        sh_shift_s = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else begin
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    sh_shift_s = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = {GAP_CW{1'b0}};
                    sh_load_s = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CW'(1);
                    state_d   = ST_GAP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = {CNT_W{1'b0}};
                gap_cnt_d = {GAP_CW{1'b0}};
                rep_cnt_d = {REP_W{1'b0}};
                sh_load_s = 1'b1;
                sh_din_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= {CNT_W{1'b0}};
            gap_cnt_q <= {GAP_CW{1'b0}};
            rep_cnt_q <= {REP_W{1'b0}};
            hold_q    <= {WIDTH{1'b0}};
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            hold_q    <= hold_d;
            ready_q   <= (state_d == ST_IDLE);
            valid_q   <= (state_d == ST_SHIFT);
            done_q    <= (state_d == ST_DONE);
        end
    end

    // The shift register's MSB flop is the dout register itself
    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load_s),
        .shift_i (sh_shift_s),
        .din_i   (sh_din_s),
        .msb_o   (dout)
    );

    assign ready      = ready_q;
    assign dout_valid = valid_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_bit_seq_tx.sv
// Bench for bit_seq_tx: one instance with GAP=2, one with GAP=0, each with a
// scoreboard queue of expected serial bits and done markers.
module tb_bit_seq_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_a = 1'b0, load_b = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] rep_in = 4'h0;
    logic       ready_a, dout_a, valid_a, done_a;
    logic       ready_b, dout_b, valid_b, done_b;
    logic [3:0] state_a, state_b;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int q_a[$];
    int q_b[$];

    always #5 clk = ~clk;

    bit_seq_tx #(.WIDTH(8), .GAP(2), .REP_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .load(load_a), .data_in(data_in), .rep_in(rep_in),
        .ready(ready_a), .dout(dout_a), .dout_valid(valid_a), .done(done_a), .state(state_a)
    );

    bit_seq_tx #(.WIDTH(8), .GAP(0), .REP_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .load(load_b), .data_in(data_in), .rep_in(rep_in),
        .ready(ready_b), .dout(dout_b), .dout_valid(valid_b), .done(done_b), .state(state_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor A: pop one expectation per valid bit or done pulse
    always @(negedge clk) begin
        int e;
        if (valid_a || done_a) begin
            if (q_a.size() == 0) begin
                chk("mon_a_unexpected", {29'd0, done_a, valid_a, dout_a}, 0);
            end else begin
                e = q_a.pop_front();
                if (e == 2) chk("mon_a_done", {29'd0, done_a, valid_a, dout_a}, 4);
                else        chk("mon_a_bit",  {29'd0, done_a, valid_a, dout_a}, 2 + e);
            end
        end else begin
            chk("mon_a_idle_dout", {31'd0, dout_a}, 0);
        end
    end

    // Monitor B: same scoreboard for the back-to-back instance
    always @(negedge clk) begin
        int e;
        if (valid_b || done_b) begin
            if (q_b.size() == 0) begin
                chk("mon_b_unexpected", {29'd0, done_b, valid_b, dout_b}, 0);
            end else begin
                e = q_b.pop_front();
                if (e == 2) chk("mon_b_done", {29'd0, done_b, valid_b, dout_b}, 4);
                else        chk("mon_b_bit",  {29'd0, done_b, valid_b, dout_b}, 2 + e);
            end
        end else begin
            chk("mon_b_idle_dout", {31'd0, dout_b}, 0);
        end
    end

    // Issue one transaction at a negedge; checks load-to-done latency, then IDLE.
    // inj_cyc: cycle at which a spurious load is raised; rst_cyc: cycle to reset.
    task automatic send(input int which, input logic [7:0] d, input int rep,
                        input int exp_cyc, input int inj_cyc, input int rst_cyc);
        int  cycles;
        int  nbits;
        bit  seen;
        nbits = (rst_cyc > 0) ? rst_cyc : (rep + 1) * 8;
        for (int n = 0; n < nbits; n++) begin
            if (which == 0) q_a.push_back(int'(d[7 - (n % 8)]));
            else            q_b.push_back(int'(d[7 - (n % 8)]));
        end
        if (rst_cyc == 0) begin
            if (which == 0) q_a.push_back(2);
            else            q_b.push_back(2);
        end
        data_in = d;
        rep_in  = 4'(rep);
        if (which == 0) load_a = 1'b1; else load_b = 1'b1;
        @(posedge clk);
        #1;
        load_a = 1'b0;
        load_b = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 200) begin
            @(negedge clk);
            cycles++;
            load_a = 1'b0;
            load_b = 1'b0;
            if (cycles == inj_cyc) begin
                data_in = 8'h00;
                rep_in  = 4'd3;
                if (which == 0) load_a = 1'b1; else load_b = 1'b1;
            end
            if (rst_cyc > 0 && cycles == rst_cyc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_state", int'(which == 0 ? state_a : state_b), 1);
                chk("rst_valid", int'(which == 0 ? valid_a : valid_b), 0);
                chk("rst_done",  int'(which == 0 ? done_a : done_b), 0);
                chk("rst_q_empty", (which == 0) ? q_a.size() : q_b.size(), 0);
                return;
            end
            seen = (which == 0) ? done_a : done_b;
        end
        chk("latency", cycles, exp_cyc);
        @(negedge clk);
        chk("ready_after", int'(which == 0 ? ready_a : ready_b), 1);
        chk("state_after", int'(which == 0 ? state_a : state_b), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_state_a", int'(state_a), 1);
        chk("reset_ready_a", int'(ready_a), 1);
        chk("reset_out_a",   {29'd0, done_a, valid_a, dout_a}, 0);
        chk("reset_state_b", int'(state_b), 1);
        chk("reset_ready_b", int'(ready_b), 1);
        @(negedge clk);

        send(0, 8'b1011_0010, 0, 9,  0, 0);
        send(0, 8'hA5,        1, 19, 0, 0);
        send(1, 8'hF0,        2, 25, 0, 0);
        send(1, 8'h3C,        0, 9,  0, 0);
        send(0, 8'hFF,        0, 9,  3, 0);
        repeat (4) @(negedge clk);
        chk("ignored_load_idle", int'(state_a), 1);
        send(0, 8'hC3,        0, 0,  0, 5);
        repeat (2) @(negedge clk);
        send(0, 8'h81,        0, 9,  0, 0);
        repeat (3) @(negedge clk);
        chk("final_q_a_empty", q_a.size(), 0);
        chk("final_q_b_empty", q_b.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
